// File: rtl/energy_monitor_seq_ctrl.sv
// Sequencer for the energy-monitor accumulator: one job per accepted spin
// vector, an internal weight-beat counter, a configurable drain latency,
// debug single-stepping and back-to-back jobs without an IDLE bubble.
module energy_monitor_seq_ctrl #(
  parameter int unsigned PIPESMID  = 1,
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             config_valid_i,
  output logic             config_ready_o,
  input  logic [CNT_W-1:0] config_beats_i,
  input  logic             spin_valid_i,
  output logic             spin_ready_o,
  input  logic             weight_valid_i,
  output logic             weight_ready_o,
  output logic             accum_clr_o,
  output logic             accum_en_o,
  output logic [CNT_W-1:0] beat_idx_o,
  output logic             energy_valid_o,
  input  logic             energy_ready_i,
  input  logic             debug_en_i,
  input  logic             debug_step_i,
  output logic             busy_o
);

  localparam int unsigned DrainW = (PIPESMID > 0) ? $clog2(PIPESMID + 1) : 1;

  typedef enum logic [1:0] {StIdle, StCompute, StDrain, StOutput} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic                valid_q;
  logic                active;
  logic [CNT_W-1:0]    cfg_clamped;

  // Outputs are also held low while reset is asserted, so an abort is visible at once.
  assign active         = en_i & rst_ni;
  assign energy_valid_o = valid_q & active;
  assign busy_o         = (state_q != StIdle);
  assign beat_idx_o     = beat_cnt_q;

  // Zero beats means one beat; anything beyond the counter range saturates.
  always_comb begin
    cfg_clamped = config_beats_i;
    if (config_beats_i == '0) begin
      cfg_clamped = CNT_W'(1);
    end else if (config_beats_i > CNT_W'(MAX_BEATS)) begin
      cfg_clamped = CNT_W'(MAX_BEATS);
    end
  end

  // Next-state, counter updates and handshake outputs.
  always_comb begin
    state_d        = state_q;
    beats_d        = beats_q;
    beat_cnt_d     = beat_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    config_ready_o = 1'b0;
    spin_ready_o   = 1'b0;
    weight_ready_o = 1'b0;
    accum_clr_o    = 1'b0;
    accum_en_o     = 1'b0;
    case (state_q)
      StIdle: begin
        config_ready_o = active & ~debug_en_i;
        spin_ready_o   = active & ~debug_en_i & ~config_valid_i;
        if (config_valid_i && config_ready_o) begin
          beats_d = cfg_clamped;
        end
        if (spin_valid_i && spin_ready_o) begin
          accum_clr_o = 1'b1;
          beat_cnt_d  = '0;
          state_d     = StCompute;
        end
      end
      StCompute: begin
        weight_ready_o = active & (~debug_en_i | debug_step_i);
        if (weight_valid_i && weight_ready_o) begin
          accum_en_o = 1'b1;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == beats_q - CNT_W'(1)) begin
            if (PIPESMID == 0) begin
              state_d = StOutput;
            end else begin
              state_d     = StDrain;
              drain_cnt_d = DrainW'(PIPESMID);
            end
          end
        end
      end
      StDrain: begin
        if (active) begin
          drain_cnt_d = drain_cnt_q - DrainW'(1);
          if (drain_cnt_q <= DrainW'(1)) begin
            state_d = StOutput;
          end
        end
      end
      StOutput: begin
        spin_ready_o = active & energy_ready_i & ~debug_en_i & ~config_valid_i;
        if (spin_valid_i && spin_ready_o) begin
          accum_clr_o = 1'b1;
          beat_cnt_d  = '0;
          state_d     = StCompute;
        end else if (energy_valid_o && energy_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; everything freezes while en_i is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      beats_q     <= CNT_W'(MAX_BEATS);
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      valid_q     <= 1'b0;
    end else if (en_i) begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      valid_q     <= (state_d == StOutput);
    end
  end

endmodule

// File: doc/energy_monitor_seq_ctrl.md
Name: energy_monitor_seq_ctrl

Overview:
Parametrised successor to the energy monitor control FSM. It sequences one energy computation per accepted spin vector and owns the weight-beat counter internally, so no external counter_ready is needed. It also owns a configurable datapath drain latency, debug single-stepping, and back-to-back jobs without returning to IDLE. It sits between the config, spin and weight streams and the energy-monitor accumulator datapath.

Parameters:
PIPESMID, 1, datapath latency in cycles from the last accepted weight beat to a settled result; 0 is legal.
MAX_BEATS, 256, maximum weight beats per job; must be 1 or more.
CNT_W, $clog2(MAX_BEATS+1), derived width of the beat counter and config field; not to be overridden.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
en_i  in  1  module enable; when low, state and counters freeze
config_valid_i  in  1  config request
config_ready_o  out  1  config accept
config_beats_i  in  CNT_W  weight beats per job, latched on config handshake
spin_valid_i  in  1  spin vector available
spin_ready_o  out  1  spin accept; a handshake starts a job
weight_valid_i  in  1  weight beat available
weight_ready_o  out  1  weight beat accept
accum_clr_o  out  1  one-cycle accumulator clear, coincident with the spin handshake
accum_en_o  out  1  accumulate strobe, high on every weight handshake
beat_idx_o  out  CNT_W  index of the current beat (0-based)
energy_valid_o  out  1  result valid, registered
energy_ready_i  in  1  result accept
debug_en_i  in  1  debug mode
debug_step_i  in  1  in debug mode, permits exactly one weight beat this cycle
busy_o  out  1  high when state is not IDLE

Behaviour:
- Clock and reset: single clock clk_i; rst_ni asynchronous, active-low.
- Reset values:
  - state IDLE
  - beats_q = MAX_BEATS, beat_cnt = 0, drain_cnt = 0
  - all outputs 0
- A reset asserted mid-job aborts the job immediately. No result is produced and energy_valid_o drops asynchronously.
- Config latching:
  - config_beats_i = 0 latches 1.
  - Values above MAX_BEATS latch MAX_BEATS.
  - The new value applies from the next spin handshake.
- Output gating: every ready/strobe output is ANDed with en_i.
- en_i low:
  - energy_valid_o is forced 0; the registered flag is preserved and reappears when en_i returns.
  - No handshake is counted.
- States: IDLE, COMPUTE, DRAIN, OUTPUT (2-bit encoding).
- IDLE:
  - config_ready_o = !debug_en_i.
  - spin_ready_o = !debug_en_i && !config_valid_i; config has priority when both are valid.
  - On spin handshake: accum_clr_o = 1 that cycle, beat_cnt <= 0, next state COMPUTE.
- COMPUTE:
  - weight_ready_o = !debug_en_i || debug_step_i.
  - Each weight handshake: accum_en_o = 1, beat_cnt++.
  - Handshake with beat_cnt == beats_q-1: next state DRAIN with drain_cnt <= PIPESMID, or OUTPUT directly if PIPESMID == 0.
  - beat_cnt never wraps; beat_idx_o = beat_cnt.
- DRAIN:
  - drain_cnt decrements each enabled cycle.
  - When drain_cnt == 1: next state OUTPUT.
  - Unaffected by debug_en_i.
  - Latency: energy_valid_o rises exactly PIPESMID+1 enabled cycles after the last weight handshake.
- OUTPUT:
  - energy_valid_o = 1 and stays high until energy_ready_i.
  - No ready outputs, except spin_ready_o = energy_ready_i && !debug_en_i && !config_valid_i.
  - Energy and spin handshake in the same cycle: accum_clr_o = 1, beat_cnt <= 0, next state COMPUTE (back-to-back job, no IDLE bubble).
  - Energy handshake alone: next state IDLE.
- Debug:
  - Blocks new config and spin in IDLE and OUTPUT.
  - In COMPUTE, at most one beat per cycle in which debug_step_i is high.
  - Does not stall DRAIN or a pending result.
- Illegal state encoding recovers to IDLE.

Test Plan:
1. Reset, config_beats_i=4, PIPESMID=1, spin, 4 consecutive weight beats, energy_ready_i=1 -> accum_clr_o one pulse; accum_en_o 4 pulses with beat_idx_o 0..3; energy_valid_o high 2 cycles after the 4th beat for 1 cycle; return to IDLE.
2. config_beats_i=0, then 300 with MAX_BEATS=256 -> jobs run 1 beat and 256 beats respectively.
3. energy_ready_i low for 5 cycles while spin_valid_i=1 -> energy_valid_o held; on ready, same-cycle spin handshake, accum_clr_o=1, state COMPUTE next cycle, busy_o never drops.
4. debug_en_i=1 in COMPUTE with weight_valid_i=1 and debug_step_i pulsed 3 times -> exactly 3 accum_en_o pulses; config_ready_o=0 throughout.
5. en_i low for 3 cycles mid-COMPUTE and in OUTPUT -> beat_cnt frozen; outputs 0; result reappears after en_i returns, with identical remaining beat count.
6. rst_ni asserted during DRAIN -> all outputs 0 asynchronously; the next job runs with beats_q = MAX_BEATS.
